// File: rtl/parser_rule_cfg_arbiter_if.sv
// Rule-configuration bus bundle shared between the two requesters, the
// arbiter and the parser rule port.
//   i_req_valid/i_req_wr  [1:0]  per-requester request valid / write flag
//   i_req_addr/i_req_wdata [63:0] {req1, req0} address / write data
//   o_req_ready/o_resp_valid [1:0] accept strobe / completion pulse
//   o_resp_rdata/o_resp_err        completion payload
//   o_rule_*                       parser rule port (strobes, addr, wdata)
//   i_rule_rdata_valid/i_rule_rdata parser read return
//   o_busy                         arbiter not idle
// slave: arbiter side; master: requesters + parser side.
interface parser_rule_cfg_arbiter_if;
   logic [1:0]  i_req_valid;
   logic [1:0]  i_req_wr;
   logic [63:0] i_req_addr;
   logic [63:0] i_req_wdata;
   logic [1:0]  o_req_ready;
   logic [1:0]  o_resp_valid;
   logic [31:0] o_resp_rdata;
   logic        o_resp_err;
   logic        o_rule_wren;
   logic        o_rule_rden;
   logic [31:0] o_rule_addr;
   logic [31:0] o_rule_wdata;
   logic        i_rule_rdata_valid;
   logic [31:0] i_rule_rdata;
   logic        o_busy;

   modport slave (
      input  i_req_valid, i_req_wr, i_req_addr, i_req_wdata,
      input  i_rule_rdata_valid, i_rule_rdata,
      output o_req_ready, o_resp_valid, o_resp_rdata, o_resp_err,
      output o_rule_wren, o_rule_rden, o_rule_addr, o_rule_wdata, o_busy
   );

   modport master (
      output i_req_valid, i_req_wr, i_req_addr, i_req_wdata,
      output i_rule_rdata_valid, i_rule_rdata,
      input  o_req_ready, o_resp_valid, o_resp_rdata, o_resp_err,
      input  o_rule_wren, o_rule_rden, o_rule_addr, o_rule_wdata, o_busy
   );
endinterface

// File: rtl/parser_rule_cfg_arbiter.sv
// Two-requester arbiter for the parser rule-configuration port.
// Requester 0 is the boot loader, requester 1 the runtime host. One access
// is in flight at a time; completed accesses are followed by GAP_CYCLES idle
// cycles; reads are bounded by RD_TIMEOUT; rule addresses with addr[10:8]
// of 6 or 7 are rejected without touching the parser.
// Ports:
//   i_clk  clock
//   i_rst  synchronous reset, active-high
//   bus    parser_rule_cfg_arbiter_if.slave (requests, responses, rule port)
module parser_rule_cfg_arbiter #(
   parameter int unsigned GAP_CYCLES = 2,
   parameter int unsigned RD_TIMEOUT = 16,
   parameter int unsigned BOOT_PRIO  = 0
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   parser_rule_cfg_arbiter_if.slave    bus
);

   localparam int unsigned TO_W  = $clog2((RD_TIMEOUT > 2) ? RD_TIMEOUT : 2);
   localparam int unsigned GAP_W = $clog2((GAP_CYCLES > 2) ? GAP_CYCLES : 2);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(RD_TIMEOUT - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, GAP} state_t;

   state_t            state_q, state_d;
   logic              last_q, last_d;
   logic              gnt_q, gnt_d;
   logic              wr_q, wr_d;
   logic              legal_q, legal_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
   logic              wren_q, wren_d;
   logic              rden_q, rden_d;
   logic [31:0]       raddr_q, raddr_d;
   logic [31:0]       rwdata_q, rwdata_d;

   logic              g;
   logic              sel_wr;
   logic [31:0]       sel_addr;
   logic [31:0]       sel_wdata;
   logic              sel_legal;
   logic [1:0]        ready_c;
   logic [1:0]        resp_valid_c;
   logic [31:0]       resp_rdata_c;
   logic              resp_err_c;
   logic [1:0]        owner_mask;
   state_t            done_state;

   always_comb begin
      // Winner selection
      if (BOOT_PRIO != 0) begin
         g = ~bus.i_req_valid[0];
      end else if (bus.i_req_valid[~last_q]) begin
         g = ~last_q;
      end else begin
         g = last_q;
      end
      sel_wr    = bus.i_req_wr[g];
      sel_addr  = g ? bus.i_req_addr[63:32]  : bus.i_req_addr[31:0];
      sel_wdata = g ? bus.i_req_wdata[63:32] : bus.i_req_wdata[31:0];
      sel_legal = (sel_addr[10:8] < 3'd6);
      owner_mask = gnt_q ? 2'b10 : 2'b01;
      // GAP_CYCLES=0 skips the GAP state entirely so write spacing stays 2
      done_state = (GAP_CYCLES == 0) ? IDLE : GAP;

      state_d      = state_q;
      last_d       = last_q;
      gnt_d        = gnt_q;
      wr_d         = wr_q;
      legal_d      = legal_q;
      to_cnt_d     = to_cnt_q;
      gap_cnt_d    = gap_cnt_q;
      wren_d       = 1'b0;
      rden_d       = 1'b0;
      raddr_d      = raddr_q;
      rwdata_d     = rwdata_q;
      ready_c      = '0;
      resp_valid_c = '0;
      resp_rdata_c = '0;
      resp_err_c   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (|bus.i_req_valid) begin
               ready_c[g] = 1'b1;
               last_d     = g;
               gnt_d      = g;
               wr_d       = sel_wr;
               legal_d    = sel_legal;
               state_d    = ISSUE;
               // Strobes are registered, so they are launched at handshake
               // to appear during the ISSUE cycle.
               if (sel_legal) begin
                  wren_d   = sel_wr;
                  rden_d   = ~sel_wr;
                  raddr_d  = sel_addr;
                  rwdata_d = sel_wr ? sel_wdata : '0;
               end
            end
         end
         ISSUE: begin
            if (!legal_q) begin
               resp_valid_c = owner_mask;
               resp_err_c   = 1'b1;
               gap_cnt_d    = '0;
               state_d      = done_state;
            end else if (wr_q) begin
               resp_valid_c = owner_mask;
               gap_cnt_d    = '0;
               state_d      = done_state;
            end else begin
               to_cnt_d = '0;
               state_d  = WAIT_RD;
            end
         end
         WAIT_RD: begin
            if (to_cnt_q != TO_LAST) begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
            if (bus.i_rule_rdata_valid) begin
               resp_valid_c = owner_mask;
               resp_rdata_c = bus.i_rule_rdata;
               gap_cnt_d    = '0;
               state_d      = done_state;
            end else if (to_cnt_q == TO_LAST) begin
               resp_valid_c = owner_mask;
               resp_err_c   = 1'b1;
               gap_cnt_d    = '0;
               state_d      = done_state;
            end
         end
         GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               state_d = IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Reset cycle: nothing is accepted or answered
      if (i_rst) begin
         ready_c      = '0;
         resp_valid_c = '0;
         resp_rdata_c = '0;
         resp_err_c   = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= IDLE;
         last_q    <= 1'b1;
         gnt_q     <= 1'b0;
         wr_q      <= 1'b0;
         legal_q   <= 1'b0;
         to_cnt_q  <= '0;
         gap_cnt_q <= '0;
         wren_q    <= 1'b0;
         rden_q    <= 1'b0;
         raddr_q   <= '0;
         rwdata_q  <= '0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         gnt_q     <= gnt_d;
         wr_q      <= wr_d;
         legal_q   <= legal_d;
         to_cnt_q  <= to_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         wren_q    <= wren_d;
         rden_q    <= rden_d;
         raddr_q   <= raddr_d;
         rwdata_q  <= rwdata_d;
      end
   end

   assign bus.o_req_ready  = ready_c;
   assign bus.o_resp_valid = resp_valid_c;
   assign bus.o_resp_rdata = resp_rdata_c;
   assign bus.o_resp_err   = resp_err_c;
   assign bus.o_rule_wren  = wren_q;
   assign bus.o_rule_rden  = rden_q;
   assign bus.o_rule_addr  = raddr_q;
   assign bus.o_rule_wdata = rwdata_q;
   assign bus.o_busy       = (state_q != IDLE);

endmodule
